// File: rtl/pipe_register_chain.sv
// Elastic DEPTH-stage pipeline register with a valid/ready handshake, bubble
// collapsing, synchronous flush and a registered occupancy count.
module pipe_register_chain #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_v_nxt;
  logic [DEPTH-1:0] w_load;
  logic             w_accept;

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // A stage is ready when it is empty or any stage downstream of it is empty
  // or the consumer takes the head; folding from the tail avoids a comb loop.
  always_comb begin
    logic acc;
    w_rdy = '0;
    acc   = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc      = acc | ~r_v[i];
      w_rdy[i] = acc;
    end
  end

  assign in_ready = w_rdy[0] & ~flush & ~reset;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_v_nxt = r_v;
    w_load  = '0;
    if (w_rdy[0]) begin
      w_v_nxt[0] = w_accept;
      w_load[0]  = w_accept;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (w_rdy[i]) begin
        w_v_nxt[i] = r_v[i-1];
        w_load[i]  = r_v[i-1];
      end
    end
    if (flush) begin
      w_v_nxt = '0;
      w_load  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v     <= '0;
      r_count <= '0;
    end else begin
      r_v     <= w_v_nxt;
      r_count <= popcount(w_v_nxt);
    end
  end

  // Data only moves alongside a valid item, so bubbles never toggle it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_d[i] <= INIT;
    end else begin
      if (w_load[0]) r_d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (w_load[i]) r_d[i] <= r_d[i-1];
      end
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_register_chain.sv
// Bench for pipe_register_chain: a DEPTH=3 instance against a positional queue
// model, plus directed DEPTH=4 bubble and DEPTH=2 full-through instances.
module tb_pipe_register_chain;
  localparam int          AD    = 3;
  localparam logic [31:0] AINIT = 32'hDEADBEEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        a_flush = 0, a_iv = 0, a_ordy = 0, a_ir, a_ov;
  logic [31:0] a_id = 0, a_od;
  logic [1:0]  a_cnt;
  logic        b_flush = 0, b_iv = 0, b_ordy = 0, b_ir, b_ov;
  logic [7:0]  b_id = 0, b_od;
  logic [2:0]  b_cnt;
  logic        c_flush = 0, c_iv = 0, c_ordy = 0, c_ir, c_ov;
  logic [7:0]  c_id = 0, c_od;
  logic [1:0]  c_cnt;

  pipe_register_chain #(.WIDTH(32), .DEPTH(AD), .INIT(AINIT)) u_a (
    .clock(clock), .reset(reset), .flush(a_flush), .in_valid(a_iv), .in_data(a_id),
    .in_ready(a_ir), .out_valid(a_ov), .out_data(a_od), .out_ready(a_ordy), .count(a_cnt));
  pipe_register_chain #(.WIDTH(8), .DEPTH(4), .INIT(8'h00)) u_b (
    .clock(clock), .reset(reset), .flush(b_flush), .in_valid(b_iv), .in_data(b_id),
    .in_ready(b_ir), .out_valid(b_ov), .out_data(b_od), .out_ready(b_ordy), .count(b_cnt));
  pipe_register_chain #(.WIDTH(8), .DEPTH(2), .INIT(8'hA5)) u_c (
    .clock(clock), .reset(reset), .flush(c_flush), .in_valid(c_iv), .in_data(c_id),
    .in_ready(c_ir), .out_valid(c_ov), .out_data(c_od), .out_ready(c_ordy), .count(c_cnt));

  int n_pass = 0;
  int n_total = 0;

  // Reference model: ordered items (oldest first), each with its stage index.
  int          mq_p[$];
  logic [31:0] mq_d[$];
  logic [31:0] m_last = AINIT;
  logic        exp_ir, exp_ov;
  logic [31:0] exp_od;
  int          exp_cnt;

  function automatic void m_reset();
    mq_p.delete();
    mq_d.delete();
    m_last = AINIT;
  endfunction

  // Publishes the expected pre-edge outputs, then advances one clock edge.
  function automatic void m_step(input logic iv, input logic [31:0] id,
                                 input logic ordy, input logic fl);
    exp_cnt = mq_p.size();
    exp_ov  = (mq_p.size() > 0) && (mq_p[0] == AD - 1);
    exp_od  = m_last;
    if (fl) begin
      exp_ir = 1'b0;
      mq_p.delete();
      mq_d.delete();
    end else begin
      if (exp_ov && ordy) begin
        mq_p.delete(0);
        mq_d.delete(0);
      end
      for (int k = 0; k < mq_p.size(); k++) begin
        if (mq_p[k] < AD - 1 && (k == 0 || mq_p[k-1] != mq_p[k] + 1)) begin
          mq_p[k] = mq_p[k] + 1;
          if (mq_p[k] == AD - 1) m_last = mq_d[k];
        end
      end
      exp_ir = (mq_p.size() == 0) || (mq_p[mq_p.size()-1] != 0);
      if (iv && exp_ir) begin
        mq_p.push_back(0);
        mq_d.push_back(id);
      end
    end
  endfunction

  task automatic step_a(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
    @(negedge clock);
    a_iv = iv; a_id = id; a_ordy = ordy; a_flush = fl;
    #1;
    m_step(iv, id, ordy, fl);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    n_total += 5;
    if (a_ov !== 1'b0) $display("FAIL reset.out_valid got=%b exp=0", a_ov); else n_pass++;
    if (a_od !== AINIT) $display("FAIL reset.out_data got=%h exp=%h", a_od, AINIT); else n_pass++;
    if (a_cnt !== 2'd0) $display("FAIL reset.count got=%0d exp=0", a_cnt); else n_pass++;
    if (a_ir !== 1'b0) $display("FAIL reset.in_ready_held got=%b exp=0", a_ir); else n_pass++;
    if (c_od !== 8'hA5) $display("FAIL reset.c_out_data got=%h exp=a5", c_od); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    m_reset();
    #1;
    n_total += 3;
    if (a_ir !== 1'b1) $display("FAIL reset.a_in_ready got=%b exp=1", a_ir); else n_pass++;
    if (b_ir !== 1'b1) $display("FAIL reset.b_in_ready got=%b exp=1", b_ir); else n_pass++;
    if (c_ir !== 1'b1) $display("FAIL reset.c_in_ready got=%b exp=1", c_ir); else n_pass++;
  endtask

  task automatic test_streaming();
    int first = -1;
    int maxc = 0;
    logic [31:0] got[$];
    for (int c = 0; c < 10; c++) begin
      step_a(c < 4, 32'(c + 1), 1'b1, 1'b0);
      n_total += 4;
      if (a_ir !== exp_ir) $display("FAIL stream.in_ready c=%0d got=%b exp=%b", c, a_ir, exp_ir); else n_pass++;
      if (a_ov !== exp_ov) $display("FAIL stream.out_valid c=%0d got=%b exp=%b", c, a_ov, exp_ov); else n_pass++;
      if (a_od !== exp_od) $display("FAIL stream.out_data c=%0d got=%h exp=%h", c, a_od, exp_od); else n_pass++;
      if (int'(a_cnt) !== exp_cnt) $display("FAIL stream.count c=%0d got=%0d exp=%0d", c, a_cnt, exp_cnt); else n_pass++;
      if (a_ov === 1'b1) begin
        if (first < 0) first = c;
        got.push_back(a_od);
      end
      if (int'(a_cnt) > maxc) maxc = int'(a_cnt);
    end
    n_total += 3;
    if (first !== 3) $display("FAIL stream.latency got=%0d exp=3", first); else n_pass++;
    if (maxc !== 3) $display("FAIL stream.count_peak got=%0d exp=3", maxc); else n_pass++;
    if (got.size() !== 4) $display("FAIL stream.n_out got=%0d exp=4", got.size()); else n_pass++;
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_total++;
      if (got[k] !== 32'(k + 1)) $display("FAIL stream.order k=%0d got=%h exp=%h", k, got[k], k + 1); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] items [4];
    logic [31:0] got[$];
    int idx = 0;
    items = '{32'hA, 32'hB, 32'hC, 32'hD};
    for (int c = 0; c < 13; c++) begin
      step_a(idx < 4, (idx < 4) ? items[idx] : 32'h0, c >= 5, 1'b0);
      n_total += 4;
      if (a_ir !== exp_ir) $display("FAIL bp.in_ready c=%0d got=%b exp=%b", c, a_ir, exp_ir); else n_pass++;
      if (a_ov !== exp_ov) $display("FAIL bp.out_valid c=%0d got=%b exp=%b", c, a_ov, exp_ov); else n_pass++;
      if (a_od !== exp_od) $display("FAIL bp.out_data c=%0d got=%h exp=%h", c, a_od, exp_od); else n_pass++;
      if (int'(a_cnt) !== exp_cnt) $display("FAIL bp.count c=%0d got=%0d exp=%0d", c, a_cnt, exp_cnt); else n_pass++;
      if (c == 4) begin
        n_total += 3;
        if (a_ir !== 1'b0) $display("FAIL bp.full_in_ready got=%b exp=0", a_ir); else n_pass++;
        if (a_cnt !== 2'd3) $display("FAIL bp.full_count got=%0d exp=3", a_cnt); else n_pass++;
        if (a_od !== 32'hA) $display("FAIL bp.full_head got=%h exp=a", a_od); else n_pass++;
      end
      if (a_ov === 1'b1 && a_ordy) got.push_back(a_od);
      if (a_iv && a_ir === 1'b1) idx++;
    end
    n_total++;
    if (got.size() !== 4) $display("FAIL bp.n_out got=%0d exp=4", got.size()); else n_pass++;
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      n_total++;
      if (got[k] !== items[k]) $display("FAIL bp.order k=%0d got=%h exp=%h", k, got[k], items[k]); else n_pass++;
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) step_a(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
    step_a(1'b1, 32'h1FF, 1'b0, 1'b1);
    n_total += 3;
    if (a_ir !== 1'b0) $display("FAIL flush.in_ready got=%b exp=0", a_ir); else n_pass++;
    if (a_cnt !== 2'd3) $display("FAIL flush.count_before got=%0d exp=3", a_cnt); else n_pass++;
    if (a_ir !== exp_ir) $display("FAIL flush.model_in_ready got=%b exp=%b", a_ir, exp_ir); else n_pass++;
    step_a(1'b0, 32'h0, 1'b0, 1'b0);
    n_total += 3;
    if (a_cnt !== 2'd0) $display("FAIL flush.count_after got=%0d exp=0", a_cnt); else n_pass++;
    if (a_ov !== 1'b0) $display("FAIL flush.out_valid got=%b exp=0", a_ov); else n_pass++;
    if (a_od !== 32'h100) $display("FAIL flush.data_kept got=%h exp=100", a_od); else n_pass++;
    step_a(1'b0, 32'h0, 1'b1, 1'b0);
    n_total++;
    if (a_cnt !== 2'd0) $display("FAIL flush.not_captured got=%0d exp=0", a_cnt); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic seen = 1'b0;
    step_a(1'b1, 32'h201, 1'b0, 1'b0);
    step_a(1'b1, 32'h202, 1'b0, 1'b0);
    step_a(1'b0, 32'h0, 1'b0, 1'b0);
    n_total++;
    if (a_cnt !== 2'd2) $display("FAIL areset.count_before got=%0d exp=2", a_cnt); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total += 4;
    if (a_ov !== 1'b0) $display("FAIL areset.out_valid got=%b exp=0", a_ov); else n_pass++;
    if (a_od !== AINIT) $display("FAIL areset.out_data got=%h exp=%h", a_od, AINIT); else n_pass++;
    if (a_cnt !== 2'd0) $display("FAIL areset.count got=%0d exp=0", a_cnt); else n_pass++;
    if (a_ir !== 1'b0) $display("FAIL areset.in_ready got=%b exp=0", a_ir); else n_pass++;
    m_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_total++;
    if (a_ir !== 1'b1) $display("FAIL areset.in_ready_after got=%b exp=1", a_ir); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      step_a(c == 0, 32'h303, 1'b1, 1'b0);
      n_total += 3;
      if (a_ov !== exp_ov) $display("FAIL areset.out_valid c=%0d got=%b exp=%b", c, a_ov, exp_ov); else n_pass++;
      if (a_od !== exp_od) $display("FAIL areset.out_data c=%0d got=%h exp=%h", c, a_od, exp_od); else n_pass++;
      if (int'(a_cnt) !== exp_cnt) $display("FAIL areset.count c=%0d got=%0d exp=%0d", c, a_cnt, exp_cnt); else n_pass++;
      if (a_ov === 1'b1 && a_od === 32'h303) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b1) $display("FAIL areset.push_emerged got=%b exp=1", seen); else n_pass++;
  endtask

  task automatic test_random();
    logic iv, ordy, fl;
    logic [31:0] id;
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      id   = $urandom;
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      step_a(iv, id, ordy, fl);
      n_total += 4;
      if (a_ir !== exp_ir) $display("FAIL rand.in_ready c=%0d got=%b exp=%b", c, a_ir, exp_ir); else n_pass++;
      if (a_ov !== exp_ov) $display("FAIL rand.out_valid c=%0d got=%b exp=%b", c, a_ov, exp_ov); else n_pass++;
      if (a_od !== exp_od) $display("FAIL rand.out_data c=%0d got=%h exp=%h", c, a_od, exp_od); else n_pass++;
      if (int'(a_cnt) !== exp_cnt) $display("FAIL rand.count c=%0d got=%0d exp=%0d", c, a_cnt, exp_cnt); else n_pass++;
    end
  endtask

  task automatic test_bubble_collapse();
    b_ordy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      b_iv = (c == 0) || (c == 3);
      b_id = (c == 0) ? 8'h11 : 8'h22;
      #1;
      if (b_iv) begin
        n_total++;
        if (b_ir !== 1'b1) $display("FAIL bubble.in_ready c=%0d got=%b exp=1", c, b_ir); else n_pass++;
      end
    end
    @(negedge clock);
    b_iv = 1'b0;
    #1;
    n_total += 4;
    if (b_cnt !== 3'd2) $display("FAIL bubble.count got=%0d exp=2", b_cnt); else n_pass++;
    if (b_ov !== 1'b1) $display("FAIL bubble.out_valid got=%b exp=1", b_ov); else n_pass++;
    if (b_od !== 8'h11) $display("FAIL bubble.head got=%h exp=11", b_od); else n_pass++;
    if (b_ir !== 1'b1) $display("FAIL bubble.in_ready_stalled got=%b exp=1", b_ir); else n_pass++;
    b_ordy = 1'b1;
    @(negedge clock);
    #1;
    n_total += 2;
    if (b_ov !== 1'b1) $display("FAIL bubble.second_valid got=%b exp=1", b_ov); else n_pass++;
    if (b_od !== 8'h22) $display("FAIL bubble.second_data got=%h exp=22", b_od); else n_pass++;
    @(negedge clock);
    #1;
    n_total += 2;
    if (b_ov !== 1'b0) $display("FAIL bubble.drained_valid got=%b exp=0", b_ov); else n_pass++;
    if (b_cnt !== 3'd0) $display("FAIL bubble.drained_count got=%0d exp=0", b_cnt); else n_pass++;
    b_ordy = 1'b0;
  endtask

  task automatic test_full_through();
    c_ordy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      c_iv = 1'b1;
      c_id = 8'(k + 1);
      #1;
      n_total++;
      if (c_ir !== 1'b1) $display("FAIL full.fill_ready k=%0d got=%b exp=1", k, c_ir); else n_pass++;
    end
    @(negedge clock);
    c_iv = 1'b0;
    #1;
    n_total += 2;
    if (c_cnt !== 2'd2) $display("FAIL full.count got=%0d exp=2", c_cnt); else n_pass++;
    if (c_ir !== 1'b0) $display("FAIL full.stalled_ready got=%b exp=0", c_ir); else n_pass++;
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      c_iv = 1'b1; c_id = 8'(j + 3); c_ordy = 1'b1;
      #1;
      n_total += 4;
      if (c_ir !== 1'b1) $display("FAIL full.in_ready j=%0d got=%b exp=1", j, c_ir); else n_pass++;
      if (c_cnt !== 2'd2) $display("FAIL full.count j=%0d got=%0d exp=2", j, c_cnt); else n_pass++;
      if (c_ov !== 1'b1) $display("FAIL full.out_valid j=%0d got=%b exp=1", j, c_ov); else n_pass++;
      if (c_od !== 8'(j + 1)) $display("FAIL full.out_data j=%0d got=%h exp=%h", j, c_od, j + 1); else n_pass++;
    end
    @(negedge clock);
    c_iv = 1'b0;
    c_ordy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    test_bubble_collapse();
    test_full_through();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_register_chain.md
Name: pipe_register_chain

Overview:
- Elastic, parametrised pipeline register with valid/ready handshake.
- Holds DEPTH stages of WIDTH-bit data with per-stage valid bits, bubble collapsing, synchronous flush, and an occupancy count.
- Used between MIPS32 core units that need multi-cycle retiming or back-pressure, e.g. memory-return paths and coprocessor interfaces.
- Replaces hand-chained single registers with shared enable logic.

Parameters:
- WIDTH, 32: data width in bits, ≥1.
- DEPTH, 2: number of stages, ≥1.
- INIT, 0: reset value of every data stage, WIDTH bits.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  upstream has data on in_data.
- in_data  input  WIDTH  upstream data.
- in_ready  output  1  chain accepts in_data this cycle.
- out_valid  output  1  out_data holds a valid item.
- out_data  output  WIDTH  oldest item (stage DEPTH-1).
- out_ready  input  1  downstream consumes this cycle.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- State:
  - v[0..DEPTH-1]: valid bits.
  - d[0..DEPTH-1]: data registers.
  - Stage 0 is the input stage; stage DEPTH-1 drives the outputs.
- Reset (async, any time including mid-transfer):
  - All v=0, all d=INIT, count=0, out_valid=0.
  - in_ready=1 once reset deasserts; it is 0 while reset is high.
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = !v[i] | r[i+1].
  - in_ready = r[0] & !flush & !reset.
- Stage load: stage i loads on a clock edge when r[i]=1.
  - i=0: v[0] <= in_valid & in_ready, and d[0] <= in_data only when in_valid & in_ready.
  - i>0: v[i] <= v[i-1], and d[i] <= d[i-1] only when v[i-1]=1.
  - Data registers never toggle on bubbles.
  - When r[i]=0, stage i holds v and d.
- Bubbles collapse: an empty stage accepts from upstream even if downstream is stalled.
- Latency: with out_ready held high, an item accepted at edge t is presented on out_valid/out_data after edge t+DEPTH-1, i.e. DEPTH cycles after acceptance. Sustained throughput is 1 item/cycle.
- Transfers occur only when valid & ready are both high at a clock edge. An item is never duplicated or dropped except by flush.
- Full (all v=1) with out_ready=0: in_ready=0 and everything holds.
- Full with out_ready=1: in_ready=1, so accept and emit occur in the same cycle and count is unchanged.
- Flush:
  - At the next edge all v <= 0 and d is unchanged.
  - in_ready=0 during the flush cycle, so no input is accepted.
  - An out_valid/out_ready handshake in the flush cycle still counts as consumed downstream; the flush then empties the rest.
- Reset overrides flush.
- count: registered, equal to the popcount of v after each edge; ranges 0..DEPTH and never wraps.
- Outputs: out_valid = v[DEPTH-1], out_data = d[DEPTH-1].
- DEPTH=1 degenerates to a single-entry register with combinational in_ready = !v[0] | out_ready.

Test Plan:
- Streaming: WIDTH=32, DEPTH=3, INIT=0xDEADBEEF. Reset → out_data=0xDEADBEEF, count=0. Push 1,2,3,4 on consecutive cycles with out_ready=1 → out_valid first seen 3 cycles after acceptance of 1; sequence 1,2,3,4 on 4 consecutive cycles; count peaks at 3.
- Back-pressure: DEPTH=3, out_ready=0, push 0xA,0xB,0xC,0xD → in_ready=0 after 3 accepts, count=3, 0xD held upstream. Set out_ready=1 → 0xA,0xB,0xC,0xD emitted in order with no loss.
- Bubble collapse: DEPTH=4, push 0x11, idle 2 cycles, push 0x22, with out_ready=0 → both compact into stages 3 and 2, count=2. Release → 0x11 then 0x22 on consecutive cycles.
- Full-through: DEPTH=2 full, out_ready=1 and in_valid=1 each cycle → in_ready=1 and count stays 2 for 10 cycles; outputs match input order.
- Flush: DEPTH=3 holding 3 items, assert flush 1 cycle with in_valid=1 → in_ready=0 that cycle, next cycle count=0 and out_valid=0; the flush-cycle input is not captured.
- Async reset mid-stream: assert reset between edges with count=2 → out_valid=0 and out_data=INIT immediately, without waiting for a clock edge. Deassert → in_ready=1 and the next push emerges normally.
